// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the run sequencer and an external up/down counter.
interface counter_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             abort;
  logic             pause;
  logic             tick_en;
  logic             dir;
  logic [WIDTH-1:0] preset;
  logic             qcc_n;
  logic             cnt_clr_n;
  logic             cnt_ld_n;
  logic             cnt_m;
  logic [WIDTH-1:0] cnt_data;
  logic             cnt_tick;
  logic             busy;
  logic             done;
  logic [3:0]       rounds_left;

  modport master (
    output start, abort, pause, tick_en, dir, preset, qcc_n,
    input  cnt_clr_n, cnt_ld_n, cnt_m, cnt_data, cnt_tick, busy, done, rounds_left
  );

  modport slave (
    input  start, abort, pause, tick_en, dir, preset, qcc_n,
    output cnt_clr_n, cnt_ld_n, cnt_m, cnt_data, cnt_tick, busy, done, rounds_left
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequences an external counter: load a preset, count through ROUNDS wrap-arounds, then stop.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ROUNDS = 2
) (
  input  logic              CP,
  input  logic              CLR,
  counter_seq_ctrl_if.slave bus
);
  localparam int unsigned RW = 4;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DONE} state_e;

  state_e           state_q, state_d;
  logic             start_q, qcc_q;
  logic             clr_n_q, clr_n_d;
  logic             ld_n_q, ld_n_d;
  logic             m_q, m_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [RW-1:0]    rounds_q, rounds_d;
  logic             start_edge, fall, last_fall, tick_c;

  assign start_edge = bus.start & ~start_q;
  assign fall       = qcc_q & ~bus.qcc_n;
  assign last_fall  = fall & (rounds_q == RW'(1));

  // State and registered outputs; start_q/qcc_q reset high so levels held through reset are not edges
  always_ff @(posedge CP or negedge CLR) begin
    if (!CLR) begin
      state_q  <= IDLE;
      start_q  <= 1'b1;
      qcc_q    <= 1'b1;
      clr_n_q  <= 1'b0;
      ld_n_q   <= 1'b1;
      m_q      <= 1'b1;
      data_q   <= '0;
      rounds_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= bus.start;
      qcc_q    <= bus.qcc_n;
      clr_n_q  <= clr_n_d;
      ld_n_q   <= ld_n_d;
      m_q      <= m_d;
      data_q   <= data_d;
      rounds_q <= rounds_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next state; the final wrap suppresses the tick in that cycle so the counter parks on it
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    m_d      = m_q;
    rounds_d = rounds_q;
    clr_n_d  = 1'b1;
    tick_c   = (state_q == RUN) & bus.tick_en & ~bus.pause & ~last_fall;

    if (bus.abort) begin
      state_d  = IDLE;
      rounds_d = '0;
      clr_n_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            state_d  = LOAD;
            data_d   = bus.preset;
            m_d      = bus.dir;
            rounds_d = RW'(ROUNDS);
          end
        end
        LOAD: state_d = RUN;
        RUN, HOLD: begin
          if (last_fall) begin
            state_d  = DONE;
            rounds_d = '0;
          end else begin
            if (fall) rounds_d = rounds_q - RW'(1);
            if ((state_q == RUN) && bus.pause)       state_d = HOLD;
            else if ((state_q == HOLD) && !bus.pause) state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ld_n_d = (state_d != LOAD);
    busy_d = (state_d == LOAD) || (state_d == RUN) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  assign bus.cnt_clr_n   = clr_n_q;
  assign bus.cnt_ld_n    = ld_n_q;
  assign bus.cnt_m       = m_q;
  assign bus.cnt_data    = data_q;
  assign bus.cnt_tick    = tick_c;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rounds_left = rounds_q;
endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of preset and counter data bus.
REQ-002 Parameter ROUNDS, default 2: counter wrap-arounds per run; legal range 1..15.
REQ-003 CP  input  1  rising-edge system clock; the counter under control uses the same clock.
REQ-004 CLR  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; its rising edge requests a run.
REQ-006 abort  input  1  level; synchronous cancel, highest priority after CLR.
REQ-007 pause  input  1  level; freezes counting while high.
REQ-008 tick_en  input  1  count strobe, one count per high cycle.
REQ-009 dir  input  1  1 = up, 0 = down; sampled on the start edge.
REQ-010 preset  input  WIDTH  load value; sampled on the start edge.
REQ-011 qcc_n  input  1  terminal-count flag from the counter, low after a wrap.
REQ-012 cnt_clr_n  output  1  active-low clear to the counter.
REQ-013 cnt_ld_n  output  1  active-low load to the counter.
REQ-014 cnt_m  output  1  counter direction.
REQ-015 cnt_data  output  WIDTH  counter load data.
REQ-016 cnt_tick  output  1  counter clock enable.
REQ-017 busy  output  1  high in LOAD, RUN, HOLD.
REQ-018 done  output  1  high in DONE.
REQ-019 rounds_left  output  4  remaining wraps.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, RUN, HOLD, DONE; all outputs except cnt_tick are registered.
REQ-021 start_edge SHALL be start & ~start_d, where start_d is start registered; fall SHALL be qcc_d & ~qcc_n, where qcc_d is qcc_n registered.
REQ-022 IDLE or DONE with start_edge SHALL go to LOAD and latch preset into cnt_data, dir into cnt_m, and ROUNDS into rounds_left.
REQ-023 LOAD SHALL last exactly one cycle with cnt_ld_n=0, then go to RUN; cnt_ld_n=1 in every other state.
REQ-024 RUN with pause=1 SHALL go to HOLD; HOLD with pause=0 SHALL go to RUN.
REQ-025 cnt_tick SHALL equal (state==RUN) & tick_en & ~pause & ~(fall & rounds_left==1), combinationally.
REQ-026 In RUN or HOLD, each fall SHALL decrement rounds_left; when fall occurs with rounds_left==1, the FSM SHALL go to DONE and rounds_left SHALL become 0.
REQ-027 fall SHALL be honoured in HOLD; if it completes the last round there, the FSM SHALL go to DONE.
REQ-028 start_edge in LOAD, RUN or HOLD SHALL be ignored.
REQ-029 abort=1 in any state SHALL go to IDLE at the next edge, drive cnt_clr_n=0 for exactly that one cycle, clear rounds_left, and override start_edge and fall.
REQ-030 DONE SHALL hold until start_edge (goes to LOAD) or abort (goes to IDLE).

Reset
REQ-031 While CLR=0: state=IDLE, cnt_clr_n=0, cnt_ld_n=1, cnt_m=1, cnt_data=0, rounds_left=0, busy=0, done=0, start_d=1, qcc_d=1.
REQ-032 On the first CP edge after CLR releases, cnt_clr_n SHALL go to 1.
REQ-033 A start held high through reset release SHALL NOT start a run.

Verification
REQ-034 preset=3, dir=0, ROUNDS=2, tick_en=1: LOAD, then Q = 3,2,1,0,15,...,0,15. done rises 1 cycle after the second wrap and Q holds at 15; cnt_tick=1 for exactly 20 cycles.
REQ-035 Same run with pause=1 for 5 cycles mid-run: state is HOLD, cnt_tick=0, Q is frozen, and done is delayed by exactly 5 cycles.
REQ-036 abort during RUN with rounds_left=1: IDLE at the next edge, cnt_clr_n low for 1 cycle, Q=0, busy=0, done=0.
REQ-037 start toggled during RUN: no reload, and rounds_left is unchanged.
REQ-038 CLR asserted mid-RUN: outputs take the REQ-031 values immediately, with no CP edge required.
REQ-039 dir=1, preset=14, ROUNDS=1: Q = 14, 15, 0. done is high and cnt_tick=0 from the cycle after the wrap.
